// File: rtl/ysyx_24090013_ifu.sv
// Instruction-fetch unit: owns the fetch PC, issues single-outstanding requests to a variable-latency
// imem, and queues {pc, inst} pairs for ID. Optional zero-latency bypass: YSYX_24090013_IFU_BYPASS_EN.
module ysyx_24090013_ifu #(
  parameter int unsigned     XLEN       = 32,
  parameter int unsigned     FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_inst,
  output logic [XLEN-1:0] id_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]   infl_pc_q, infl_pc_d;
  logic              kill_q, kill_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [31:0]       inst_mem_q [FIFO_DEPTH];
  logic [XLEN-1:0]   pc_mem_q   [FIFO_DEPTH];

  logic hs_c, rsp_fire_c, fifo_empty_c, fifo_full_c, byp_c, push_c, pop_c;

  // Handshake and FIFO control
  always_comb begin
    fifo_empty_c   = (count_q == '0);
    fifo_full_c    = (count_q == CNT_W'(FIFO_DEPTH));
    imem_req_valid = (state_q == REQ) && !fifo_full_c;
    imem_req_addr  = fetch_pc_q;
    hs_c           = imem_req_valid && imem_req_ready;
    rsp_fire_c     = (state_q == WAIT) && imem_rsp_valid;
`ifdef YSYX_24090013_IFU_BYPASS_EN
    byp_c          = fifo_empty_c && !kill_q && !redirect_valid && rsp_fire_c;
`else
    byp_c          = 1'b0;
`endif
    // A bypassed instruction taken by ID in the same cycle never enters the FIFO
    push_c   = rsp_fire_c && !kill_q && !redirect_valid && !(byp_c && id_ready);
    pop_c    = !fifo_empty_c && id_ready && !redirect_valid;
    id_valid = !fifo_empty_c || byp_c;
    if (byp_c) begin
      id_inst = imem_rsp_data;
      id_pc   = infl_pc_q;
    end else if (fifo_empty_c) begin
      id_inst = '0;
      id_pc   = '0;
    end else begin
      id_inst = inst_mem_q[rd_ptr_q];
      id_pc   = pc_mem_q[rd_ptr_q];
    end
  end

  // Next-state logic; redirect overrides everything on the same edge
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    infl_pc_d  = infl_pc_q;
    kill_d     = kill_q;
    wr_ptr_d   = wr_ptr_q + PTR_W'(push_c);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop_c);
    count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        if (hs_c) begin
          state_d    = WAIT;
          fetch_pc_d = fetch_pc_q + XLEN'(4);
          infl_pc_d  = fetch_pc_q;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_d = REQ;
          kill_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & ~XLEN'(3);
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      if (((state_q == WAIT) && !imem_rsp_valid) || ((state_q == REQ) && hs_c)) kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      infl_pc_q  <= '0;
      kill_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      infl_pc_q  <= infl_pc_d;
      kill_q     <= kill_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage; contents are masked by the count, so no reset is needed
  always_ff @(posedge clk) begin
    if (push_c) begin
      inst_mem_q[wr_ptr_q] <= imem_rsp_data;
      pc_mem_q[wr_ptr_q]   <= infl_pc_q;
    end
  end

endmodule
